// File: rtl/seek_r_pkg.sv
// seek_r_pkg: shared constants for the seek_e / seek_r reduction pair.
//   SEEK_DATAWIDTH  - datapath width (replaces the legacy Datawidth define)
//   SEEK_FOLD_BITS  - fold point; seek_e and seek_r must use the same value
//   SEEK_MOD_M      - modulus 2^SEEK_FOLD_BITS - 1
//   SEEK_FIFO_DEPTH - default output FIFO depth
//   SEEK_ZERO_BITS  - extra FIFO bits per entry (1 when SEEK_R_ZERO_FLAG_EN)
// Optional feature macro: SEEK_R_ZERO_FLAG_EN.
package seek_r_pkg;

    localparam int SEEK_DATAWIDTH  = 16;
    localparam int SEEK_FOLD_BITS  = 13;
    localparam int SEEK_MOD_M      = (1 << SEEK_FOLD_BITS) - 1;
    localparam int SEEK_FIFO_DEPTH = 4;

`ifdef SEEK_R_ZERO_FLAG_EN
    localparam int SEEK_ZERO_BITS  = 1;
`else
    localparam int SEEK_ZERO_BITS  = 0;
`endif

    // Width of one FIFO entry for a given data width.
    function automatic int seek_fifo_width(input int w);
        return w + SEEK_ZERO_BITS;
    endfunction

endpackage

// File: rtl/seek_r_chk.sv
// seek_r_chk: run-time property checks for seek_r.
// Ports: clk, rst, level, out_valid, out_data (all observed, none driven).
// Properties: occupancy never exceeds DEPTH; a valid head is always < M.
module seek_r_chk #(
    parameter int W         = 16,
    parameter int FOLD_BITS = 13,
    parameter int DEPTH     = 4
) (
    input logic                   clk,
    input logic                   rst,
    input logic [$clog2(DEPTH):0] level,
    input logic                   out_valid,
    input logic [W-1:0]           out_data
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [W-1:0] M_W = W'((1 << FOLD_BITS) - 1);

    // Sample the properties on every active edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert (level <= LW'(DEPTH));
            assert (!out_valid || (out_data < M_W));
        end
    end

endmodule

// File: rtl/seek_r_fifo.sv
// seek_r_fifo: synchronous FIFO, registered storage, no bypass.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push / din        - write request and data
//   pop               - read request (head advances)
//   dout              - current head entry
//   level             - occupancy, 0..DEPTH
//   full / empty      - occupancy flags
// A push while full is accepted only when a pop happens on the same edge.
module seek_r_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [LW-1:0] r_level;

    logic          w_do_push;
    logic          w_do_pop;

    // Occupancy flags and effective push/pop qualification.
    always_comb begin
        full      = (r_level == LW'(DEPTH));
        empty     = (r_level == {LW{1'b0}});
        w_do_pop  = pop && !empty;
        // When full, the slot being written is the one being popped this edge.
        w_do_push = push && (!full || pop);
    end

    // Storage, pointers and level; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_wr    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
            r_level <= {LW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign dout  = r_mem[r_rd];
    assign level = r_level;

endmodule

// File: rtl/seek_r.sv
// seek_r: final modular reduction stage behind seek_e.
// Reduces the partially folded word modulo M = 2^FOLD_BITS - 1 in two
// registered stages (second fold, conditional subtract) and queues the
// canonical residue in a small FIFO with a valid/ready output.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_e, in_vld        - partially reduced word and its strobe (no backpressure)
//   out_data, out_valid - FIFO head and non-empty flag
//   out_ready           - consumer accepts head when out_valid && out_ready
//   level               - FIFO occupancy
//   ovf, ovf_clr        - sticky overflow flag (word dropped) and its clear
//   out_zero            - head residue is zero (only with SEEK_R_ZERO_FLAG_EN)
// Optional feature macro: SEEK_R_ZERO_FLAG_EN.
module seek_r
    import seek_r_pkg::*;
#(
    parameter int W         = SEEK_DATAWIDTH,
    parameter int FOLD_BITS = SEEK_FOLD_BITS,
    parameter int DEPTH     = SEEK_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [W-1:0]           in_e,
    input  logic                   in_vld,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
`ifdef SEEK_R_ZERO_FLAG_EN
    output logic                   out_zero,
`endif
    input  logic                   ovf_clr
);

    localparam int UB = W - FOLD_BITS;
    localparam int SW = FOLD_BITS + 1;
    localparam int FW = seek_fifo_width(W);
    localparam logic [SW-1:0] M_S = SW'((1 << FOLD_BITS) - 1);

    logic [SW-1:0]         r_s1;
    logic                  r_v1;
    logic                  r_ovf;

    logic [FOLD_BITS-1:0]  w_red;
    logic [W-1:0]          w_res;
    logic [FW-1:0]         w_din;
    logic [FW-1:0]         w_dout;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;

    // Stage 1: second fold, kept at FOLD_BITS+1 bits so the carry survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= {SW{1'b0}};
            r_v1 <= 1'b0;
        end else if (in_vld) begin
            r_s1 <= {{(SW - UB){1'b0}}, in_e[W-1:FOLD_BITS]}
                  + {1'b0, in_e[FOLD_BITS-1:0]};
            r_v1 <= 1'b1;
        end else begin
            r_s1 <= r_s1;
            r_v1 <= 1'b0;
        end
    end

    // Stage 2: s1 < 2M, so a single conditional subtract yields [0, M-1].
    always_comb begin
        if (r_s1 >= M_S) begin
            w_red = FOLD_BITS'(r_s1 - M_S);
        end else begin
            w_red = FOLD_BITS'(r_s1);
        end
        w_res = {{UB{1'b0}}, w_red};
`ifdef SEEK_R_ZERO_FLAG_EN
        w_din = {(w_red == {FOLD_BITS{1'b0}}), w_res};
`else
        w_din = w_res;
`endif
    end

    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    seek_r_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_v1),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    // Sticky overflow: a push that the full FIFO cannot take; set beats clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_v1 && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign ovf      = r_ovf;
    assign out_data = w_dout[W-1:0];
`ifdef SEEK_R_ZERO_FLAG_EN
    assign out_zero = w_dout[W];
`endif

    seek_r_chk #(
        .W         (W),
        .FOLD_BITS (FOLD_BITS),
        .DEPTH     (DEPTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .level     (level),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule
